// File: rtl/input_serial_to_parallel_if.sv
// -----------------------------------------------------------------------------
// input_serial_to_parallel_if
//   Bundles the serial line, the parallel word handshake and the status flags
//   of the receive-side deserializer. Clock and reset stay outside.
//
//   serial_in   : single-wire serial stream, idles low
//   data_ready  : consumer accepts data_out when high together with data_valid
//   data_out    : last completed word, MSB = first data bit received
//   data_valid  : data_out holds an unconsumed word
//   busy        : a frame is being shifted in
//   overrun     : sticky, a completed word was dropped
//
//   master : the deserializer (receives serial_in/data_ready, drives the rest)
//   slave  : the line driver / consumer side
// -----------------------------------------------------------------------------
interface input_serial_to_parallel_if #(
  parameter int WIDTH_OUTPUT = 128
);
  logic                    serial_in;
  logic                    data_ready;
  logic [WIDTH_OUTPUT-1:0] data_out;
  logic                    data_valid;
  logic                    busy;
  logic                    overrun;

  modport master (
    input  serial_in,
    input  data_ready,
    output data_out,
    output data_valid,
    output busy,
    output overrun
  );

  modport slave (
    output serial_in,
    output data_ready,
    input  data_out,
    input  data_valid,
    input  busy,
    input  overrun
  );
endinterface

// File: rtl/input_serial_to_parallel.sv
// -----------------------------------------------------------------------------
// input_serial_to_parallel
//   Receive-side deserializer. Hunts for a start bit (a 1) on the idle-low
//   serial line, shifts in WIDTH_OUTPUT data bits MSB first, one per CLK, and
//   presents the assembled word with a valid/ready handshake. Back-to-back
//   frames need no gap. A word that completes while the previous one is still
//   unconsumed is dropped and the sticky overrun flag is raised.
//
//   Ports:
//     CLK   : system clock, all logic on the rising edge
//     RST_N : asynchronous active-low reset
//     bus   : input_serial_to_parallel_if.master
//               serial_in, data_ready           (inputs)
//               data_out, data_valid, busy,
//               overrun                         (registered outputs)
// -----------------------------------------------------------------------------
module input_serial_to_parallel #(
  parameter int WIDTH_OUTPUT = 128
) (
  input  logic                            CLK,
  input  logic                            RST_N,
  input_serial_to_parallel_if.master      bus
);

  localparam int CNT_W = $clog2(WIDTH_OUTPUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH_OUTPUT - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t                  state_q,   state_d;
  logic [CNT_W-1:0]        cnt_q,     cnt_d;
  // Only W-1 bits need storing: the last data bit is taken straight from
  // serial_in on the completion edge.
  logic [WIDTH_OUTPUT-2:0] shift_q,   shift_d;
  logic [WIDTH_OUTPUT-1:0] data_q,    data_d;
  logic                    valid_q,   valid_d;
  logic                    busy_q,    busy_d;
  logic                    overrun_q, overrun_d;

  logic                    last_bit;
  logic [WIDTH_OUTPUT-1:0] word;

  assign last_bit = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);
  assign word     = {shift_q, bus.serial_in};

  // State register and all datapath/status flops
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.serial_in) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // A 1 during SHIFT is data; only the bit count ends the frame.
        if (last_bit) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    busy_d    = (state_d == ST_SHIFT);

    if (state_q == ST_SHIFT) begin
      // Truncating cast drops the oldest bit, which is never needed again.
      shift_d = (WIDTH_OUTPUT - 1)'({shift_q, bus.serial_in});
      cnt_d   = last_bit ? '0 : cnt_q + CNT_W'(1);
    end else begin
      cnt_d   = '0;
    end

    if (last_bit) begin
      // Load when the output slot is free or being consumed on this edge;
      // otherwise the new word is lost and overrun latches.
      if (!valid_q || bus.data_ready) begin
        data_d  = word;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && bus.data_ready) begin
      valid_d = 1'b0;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.busy       = busy_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: doc/input_serial_to_parallel.md
Name: input_serial_to_parallel

Overview:
Receive-side deserializer, the counterpart of the output parallel-to-serial block. Hunts for a start bit on a single-wire serial stream, shifts in WIDTH_OUTPUT data bits MSB first, and presents the assembled word on a parallel bus with a valid/ready handshake. Sits at the readout link input, ahead of buffering or consumer logic; a sticky overrun flag reports lost words.

Parameters:
WIDTH_OUTPUT, 128, number of data bits per frame and width of data_out (legal range 2 to 1024).

Ports:
CLK  input  1  single system clock, all logic on rising edge
RST_N  input  1  asynchronous active-low reset
serial_in  input  1  serial line, sampled every rising CLK edge; idles low
data_ready  input  1  consumer accepts data_out when high with data_valid
data_out  output  WIDTH_OUTPUT  last completed word, MSB = first data bit received
data_valid  output  1  data_out holds an unconsumed word
busy  output  1  high while a frame is being shifted in (state SHIFT)
overrun  output  1  sticky; set when a completed word is dropped

Behaviour:
- Reset (async assert, sync to CLK on release): state=IDLE, bit counter=0, shift register=0, data_out=0, data_valid=0, busy=0, overrun=0. A frame in progress is discarded; no partial word is ever presented.
- Frame format: one start bit (1), then WIDTH_OUTPUT data bits MSB first, one bit per CLK. No stop bit or gap is required; back-to-back frames are legal.
- FSM, 2 states:
  - IDLE: serial_in=0 -> stay. serial_in=1 at an edge -> SHIFT, counter<=0.
  - SHIFT: each edge shift_reg <= {shift_reg[W-2:0], serial_in}, counter++. On the edge where counter==W-1 (last data bit sampled) -> IDLE, counter<=0, completion event fires.
- Counter width: clog2(WIDTH_OUTPUT). It never wraps past W-1.
- busy = (state==SHIFT), registered.
- Completion event, on the same edge the last bit is sampled; word = {shift_reg[W-2:0], serial_in}:
  - data_valid==0, or data_valid==1 && data_ready==1: data_out<=word, data_valid<=1 (stays 1 on the simultaneous consume+load case).
  - data_valid==1 && data_ready==0: word dropped, data_out and data_valid unchanged, overrun<=1.
- Latency: data_valid rises on the rising edge that samples the last data bit. The word is visible the cycle after that bit is presented, 1+W cycles after the start bit is presented.
- Consumption: data_valid && data_ready at an edge with no completion -> data_valid<=0. data_out holds its value after consumption (no clearing).
- data_ready while data_valid==0 has no effect.
- overrun clears only by reset.
- A start bit in the cycle immediately after completion is accepted (IDLE sees it on the next edge). A 1 on serial_in during SHIFT is always data, never a resync.
- No X propagation: all outputs are registered and reset.

Test Plan:
- W=128, data_ready=1: reset 100 ns, then drive 1, then 128'hA5A5…A5 MSB first, then line 0 -> data_valid pulses 1 cycle, data_out=128'hA5A5…A5 on the edge after bit 0, busy high for exactly 128 cycles, overrun=0.
- W=8, data_ready=0: frame 1,10100101 -> data_valid=1 with data_out=8'hA5 held indefinitely. Raise data_ready one cycle -> data_valid falls next edge, data_out stays 8'hA5.
- W=8 back-to-back: frames 8'h3C then 8'hC3 with no idle gap, data_ready=1 -> two valid words in order, the second valid 9 cycles after the first, overrun=0.
- W=8 overrun: data_ready=0, send 8'h11 then 8'h22 -> data_out=8'h11, overrun=1 at the second completion edge. data_ready=1 then a third frame 8'h33 -> 8'h11 consumed, 8'h33 loaded, overrun stays 1.
- W=8 simultaneous: data_valid=1 with data_ready=1 on the completion edge of 8'h5A -> data_valid stays 1, data_out=8'h5A, overrun=0.
- Reset mid-frame: assert RST_N=0 after 4 data bits of a W=8 frame (between edges) -> busy, data_valid, overrun, data_out go 0 immediately. After release, a line idling 0 produces no data_valid for 50 cycles; a new frame 8'hF0 is received correctly.
